debouncer: RTL and testbench

- Synchronizes a noisy asynchronous level input, e.g. a pushbutton, and produces a clean debounced level plus one-cycle edge pulses.
- Receiving end of the bounce-stimulus path: simulation benches drive it from the bounce generator, and top-level designs place it between board buttons and user logic.
- Built as a synchronizer chain feeding a 4-state debounce FSM with a stability counter.

---
 rtl/debouncer.sv | 124 ++++++++++++
 tb/tb_debouncer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/debouncer.sv
// Debouncer: synchronizer chain feeding a 4-state stability FSM with registered level and edge pulses.
// Optional DEBOUNCER_COUNT_EN adds transition_count, a wrapping count of debounced rising edges.
module debouncer #(
    parameter int DEBOUNCE_CLKS = 1000,
    parameter int SYNC_STAGES   = 2,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic debounce_out,
    output logic rise_pulse,
    output logic fall_pulse
`ifdef DEBOUNCER_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] transition_count
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

    if (DEBOUNCE_CLKS < 2 || DEBOUNCE_CLKS > (1 << 24)) begin : g_bad_clks
        $error("DEBOUNCE_CLKS out of range 2..2^24");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES out of range 2..4");
    end
    if (COUNT_WIDTH < 1) begin : g_bad_count
        $error("COUNT_WIDTH must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_in;
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       count, count_nxt, count_inc;
    logic                   out_nxt, rise_nxt, fall_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) sync_ff <= '0;
        else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], sig_in};
    end

    assign sync_in   = sync_ff[SYNC_STAGES-1];
    assign count_inc = (count == CNT_MAX) ? count : count + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOW;
            count        <= '0;
            debounce_out <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            debounce_out <= out_nxt;
            rise_pulse   <= rise_nxt;
            fall_pulse   <= fall_nxt;
        end
    end

    // Branch polarity is chosen so an X on sync_in falls into "keep current level".
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch.
        state_nxt = state;
        count_nxt = count;
        unique case (state)
            LOW: begin
                if (sync_in) begin
                    state_nxt = WAIT_HIGH;
                    count_nxt = '0;
                end
            end
            WAIT_HIGH: begin
                if (sync_in) begin
                    if (count == CNT_LAST) state_nxt = HIGH;
                    else                   count_nxt = count_inc;
                end else begin
                    state_nxt = LOW;
                    count_nxt = '0;
                end
            end
            HIGH: begin
                if (!sync_in) begin
                    state_nxt = WAIT_LOW;
                    count_nxt = '0;
                end
            end
            WAIT_LOW: begin
                if (!sync_in) begin
                    if (count == CNT_LAST) state_nxt = LOW;
                    else                   count_nxt = count_inc;
                end else begin
                    state_nxt = HIGH;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = LOW;
                count_nxt = '0;
            end
        endcase
    end

    // Next-cycle output values; registered alongside the state.
    always_comb begin
        out_nxt  = (state_nxt == HIGH) || (state_nxt == WAIT_LOW);
        rise_nxt = (state == WAIT_HIGH) && (state_nxt == HIGH);
        fall_nxt = (state == WAIT_LOW) && (state_nxt == LOW);
    end

`ifdef DEBOUNCER_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)           transition_count <= '0;
        else if (rise_nxt) transition_count <= transition_count + COUNT_WIDTH'(1);
    end
`endif

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer: directed latency/boundary cases plus randomized bounce bursts
// compared each cycle against a run-length reference model.
module tb_debouncer;

    localparam int D  = 10;
    localparam int S  = 2;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_in = 1'b0;
    logic debounce_out, rise_pulse, fall_pulse;
`ifdef DEBOUNCER_COUNT_EN
    logic [CW-1:0] transition_count;
`endif

    always #5 clk = ~clk;

    debouncer #(
        .DEBOUNCE_CLKS(D),
        .SYNC_STAGES  (S),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .debounce_out(debounce_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse)
`ifdef DEBOUNCER_COUNT_EN
        ,
        .transition_count(transition_count)
`endif
    );

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Reference model: sig_in delayed S clocks, output flips after D+1 consecutive differing samples.
    bit [S-1:0] m_delay;
    bit         m_out, m_rise, m_fall;
    int         m_run, m_tc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit s, input bit r);
        bit seen;
        if (r) begin
            m_delay = '0;
            m_out   = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_run   = 0;
            m_tc    = 0;
        end else begin
            seen   = m_delay[S-1];
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run  = (seen != m_out) ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_out = seen;
                m_run = 0;
                if (seen) begin
                    m_rise = 1'b1;
                    m_tc   = (m_tc + 1) % (1 << CW);
                end else begin
                    m_fall = 1'b1;
                end
            end
            m_delay = {m_delay[S-2:0], s};
        end
    endtask

    task automatic step(input bit s, input bit r);
        sig_in = s;
        rst    = r;
        @(posedge clk);
        model_edge(s, r);
        #1;
        pulses += int'(rise_pulse === 1'b1) + int'(fall_pulse === 1'b1);
        check("debounce_out", debounce_out, m_out);
        check("rise_pulse", rise_pulse, m_rise);
        check("fall_pulse", fall_pulse, m_fall);
`ifdef DEBOUNCER_COUNT_EN
        check("transition_count", transition_count, m_tc);
`endif
    endtask

    task automatic hold(input bit v, input int n);
        repeat (n) step(v, 1'b0);
    endtask

    // Counts edges after the first sampling edge until the output reaches v (bounded).
    task automatic measure(input bit v, input string tag);
        int n;
        step(v, 1'b0);
        n = 0;
        while (debounce_out !== v && n < 50) begin
            step(v, 1'b0);
            n++;
        end
        check({tag, "_latency"}, n, S + D);
        check({tag, "_pulse"}, v ? rise_pulse : fall_pulse, 1);
        step(v, 1'b0);
        check({tag, "_pulse_one_cycle"}, v ? rise_pulse : fall_pulse, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit cur, target, lvl;
        int nb;

        repeat (3) step(1'b0, 1'b1);
        check("reset_out", debounce_out, 0);
        check("reset_rise", rise_pulse, 0);
        check("reset_fall", fall_pulse, 0);
        hold(1'b0, 3);

        measure(1'b1, "clean_rise");

        pulses = 0;
        hold(1'b0, 4); hold(1'b1, 7); hold(1'b0, 9); hold(1'b1, 3);
        check("bounce_fall_quiet", pulses, 0);
        check("bounce_fall_level", debounce_out, 1);
        measure(1'b0, "bounce_fall");

        pulses = 0;
        hold(1'b1, 4); hold(1'b0, 7); hold(1'b1, 9); hold(1'b0, 3);
        check("bounce_rise_quiet", pulses, 0);
        check("bounce_rise_level", debounce_out, 0);
        measure(1'b1, "bounce_rise");

        hold(1'b0, 15);
        check("window_prep", debounce_out, 0);
        hold(1'b1, D);
        hold(1'b0, S);
        check("window_d_samples", debounce_out, 0);
        hold(1'b0, 5);
        hold(1'b1, D + 1);
        hold(1'b0, S);
        check("window_d_plus_1", debounce_out, 1);
        hold(1'b0, 15);
        check("window_back_low", debounce_out, 0);

        // Counter reaches 6 on the ninth edge of a fresh stable 1.
        hold(1'b1, S + 1 + 6);
        step(1'b1, 1'b1);
        check("rst_mid_wait_out", debounce_out, 0);
        step(1'b1, 1'b1);
        check("rst_mid_wait_hold", debounce_out, 0);
        measure(1'b1, "rst_release");

        cur = 1'b1;
        for (int t = 0; t < 50; t++) begin
            target = !cur;
            pulses = 0;
            nb     = $urandom_range(0, 4);
            lvl    = target;
            for (int b = 0; b < nb; b++) begin
                hold(lvl, $urandom_range(1, D - 1));
                lvl = !lvl;
            end
            hold(target, $urandom_range(S + D + 2, 30));
            check("rand_level", debounce_out, target);
            check("rand_one_pulse", pulses, 1);
            cur = target;
        end

`ifdef DEBOUNCER_COUNT_EN
        repeat (2) step(1'b0, 1'b1);
        check("count_reset", transition_count, 0);
        for (int p = 0; p < 257; p++) begin
            hold(1'b1, S + D + 2);
            hold(1'b0, S + D + 2);
        end
        check("count_wrap", transition_count, 1);
        step(1'b0, 1'b1);
        check("count_rst_clear", transition_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
